sr04_dist_ascii_tx: RTL and testbench

Downstream consumer of the ultrasonic distance controller. On each measurement-complete pulse it latches the 12-bit distance, converts it to four BCD digits with a sequential shift-add-3 (double dabble) engine, and streams the result as six ASCII bytes ("DDDD\r\n") into the UART transmitter through a start/done byte handshake. It sits between the SR04 controller's `o_dist`/`start_send` outputs and the UART TX byte interface.

---
 rtl/sr04_dist_ascii_tx_if.sv | 34 +++
 rtl/sr04_dist_ascii_tx.sv | 151 +++++++++++++++
 tb/tb_sr04_dist_ascii_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sr04_dist_ascii_tx_if.sv
// sr04_dist_ascii_tx_if
//   Bundles the measurement input and the UART TX byte handshake of
//   sr04_dist_ascii_tx.
//   slave  : the converter side (takes measurement + tx_done, drives TX byte).
//   master : the environment side (SR04 controller + UART TX).
//   Signals:
//     i_start_send  one-cycle pulse, new distance available
//     i_dist        distance in mm, sampled on an accepted start
//     i_tx_done     one-cycle pulse, UART finished the current byte
//     o_tx_start    one-cycle pulse, load o_tx_data into the UART
//     o_tx_data     byte being sent
//     o_busy        measurement in progress
//     o_overrun     sticky, start arrived while busy
interface sr04_dist_ascii_tx_if #(
  parameter int DIST_W = 12
);
  logic              i_start_send;
  logic [DIST_W-1:0] i_dist;
  logic              i_tx_done;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              o_busy;
  logic              o_overrun;

  modport slave (
    input  i_start_send, i_dist, i_tx_done,
    output o_tx_start, o_tx_data, o_busy, o_overrun
  );

  modport master (
    output i_start_send, i_dist, i_tx_done,
    input  o_tx_start, o_tx_data, o_busy, o_overrun
  );
endinterface

// File: rtl/sr04_dist_ascii_tx.sv
// sr04_dist_ascii_tx
//   Latches a distance on each start pulse, converts it to BCD with a
//   sequential shift-add-3 engine (one bit per clock) and streams it to a
//   UART as "DDDD\r\n" through a start/done byte handshake.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  sr04_dist_ascii_tx_if.slave (measurement in, UART byte out)
module sr04_dist_ascii_tx #(
  parameter int DIST_W     = 12,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sr04_dist_ascii_tx_if.slave   bus
);

  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam int CNT_W    = $clog2(DIST_W);
  localparam int LAST_IDX = NUM_DIGITS + 1;   // index of the trailing '\n'

  typedef enum logic [1:0] {IDLE, CONV, SEND, WAIT_DONE} state_t;

  state_t             state_q,    state_d;
  logic [DIST_W-1:0]  bin_q,      bin_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [2:0]         idx_q,      idx_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               busy_q,     busy_d;
  logic               overrun_q,  overrun_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DIST_W-1]};

  // Byte for a given stream position: digits most significant first, then CR, LF.
  function automatic logic [7:0] ascii_byte(input logic [2:0] idx,
                                            input logic [BCD_W-1:0] bcd);
    logic [3:0] digit;
    digit      = 4'h0;
    ascii_byte = 8'h0A;
    if (int'(idx) < NUM_DIGITS) begin
      digit      = bcd[(NUM_DIGITS - 1 - int'(idx)) * 4 +: 4];
      ascii_byte = {4'h3, digit};
    end else if (int'(idx) == NUM_DIGITS) begin
      ascii_byte = 8'h0D;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    // busy_q is still high on the edge that consumes the final done, so a
    // start coinciding with it is dropped too.
    if (bus.i_start_send && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start_send) begin
          bin_d   = bus.i_dist;
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIST_W - 1)) begin
          // Final iteration: first byte is taken from the freshly shifted value.
          state_d    = SEND;
          tx_start_d = 1'b1;
          tx_data_d  = ascii_byte(idx_q, bcd_shift);
        end
      end
      SEND: begin
        // tx_start/tx_data were registered on entry; this cycle is the pulse.
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_tx_done) begin
          if (idx_q == 3'(LAST_IDX)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            idx_d      = idx_q + 3'd1;
            state_d    = SEND;
            tx_start_d = 1'b1;
            tx_data_d  = ascii_byte(idx_q + 3'd1, bcd_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_sr04_dist_ascii_tx.sv
// Directed bench for sr04_dist_ascii_tx: a UART model answering each byte
// 20 cycles after its start, plus overrun, mid-transfer reset, back-to-back
// and spurious-done scenarios.
module tb_sr04_dist_ascii_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr04_dist_ascii_tx_if #(.DIST_W(12)) bus ();

  sr04_dist_ascii_tx #(.DIST_W(12), .NUM_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Pulse monitor: total tx_start count and back-to-back pulse detection.
  int   start_total = 0;
  bit   dbl_start   = 1'b0;
  logic prev_start  = 1'b0;
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      start_total++;
      if (prev_start === 1'b1) dbl_start = 1'b1;
    end
    prev_start = bus.o_tx_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_start_send = 1'b0;
    bus.i_tx_done    = 1'b0;
    bus.i_dist       = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives one measurement and plays the UART side. Returns the observed
  // byte stream and timing observations; callers do the checking.
  task automatic run_stream(input logic [11:0] d, input int ovr_byte,
                            input int abort_byte, input bit spur,
                            output logic [47:0] bytes, output int first_lat,
                            output int gap_bad, output int hold_bad,
                            output logic busy_acc, output logic busy_end);
    int cnt;
    logic [7:0] b_now;
    bytes     = '0;
    first_lat = -1;
    gap_bad   = 0;
    hold_bad  = 0;
    busy_end  = 1'bx;
    bus.i_dist       = d;
    bus.i_start_send = 1'b1;
    tick();
    bus.i_start_send = 1'b0;
    busy_acc = bus.o_busy;
    for (int b = 0; b < 6; b++) begin
      cnt = 0;
      while (bus.o_tx_start !== 1'b1 && cnt < 200) begin
        if (spur && b == 0 && cnt == 4) bus.i_tx_done = 1'b1;  // lands in CONV
        tick();
        bus.i_tx_done = 1'b0;
        cnt++;
      end
      if (bus.o_tx_start !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL stream_timeout: byte %0d got no tx_start required tx_start within 200 cycles", b);
        return;
      end
      if (b == 0) first_lat = cnt;
      else if (cnt != 0) gap_bad++;
      b_now = bus.o_tx_data;
      bytes[47 - 8*b -: 8] = b_now;
      $display("dist %0d byte %0d = 0x%02h", d, b, b_now);
      for (int k = 0; k < 20; k++) begin
        if (spur && k == 0) bus.i_tx_done = 1'b1;  // lands on the SEND edge
        if (b == ovr_byte && k == 5) begin
          bus.i_start_send = 1'b1;
          bus.i_dist       = 12'd500;
        end
        if (b == abort_byte && k == 5) rst = 1'b1;
        tick();
        bus.i_tx_done    = 1'b0;
        bus.i_start_send = 1'b0;
        if (b == abort_byte && k == 5) begin
          rst = 1'b0;
          return;
        end
        if (bus.o_tx_data !== b_now) hold_bad++;
      end
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      if (b == 5) busy_end = bus.o_busy;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.o_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b required 0", bus.o_tx_start); end
    n_vec++; if (bus.o_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h required 00", bus.o_tx_data); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.o_busy); end
    n_vec++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b required 0", bus.o_overrun); end
  endtask

  task automatic test_basic();
    logic [47:0] bytes; int lat, gb, hb, s0; logic ba, be;
    do_reset();
    s0 = start_total;
    run_stream(12'd1230, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    idle_ticks(40);
    n_vec++; if (bytes !== 48'h313233300D0A) begin n_err++; $display("FAIL basic_bytes: got %h required 313233300d0a", bytes); end
    n_vec++; if (lat != 12) begin n_err++; $display("FAIL basic_first_latency: got %0d required 12", lat); end
    n_vec++; if (ba !== 1'b1) begin n_err++; $display("FAIL basic_busy_on_accept: got %b required 1", ba); end
    n_vec++; if (be !== 1'b0) begin n_err++; $display("FAIL basic_busy_after_last_done: got %b required 0", be); end
    n_vec++; if (gb != 0) begin n_err++; $display("FAIL basic_byte_gap: got %0d late starts required 0", gb); end
    n_vec++; if (hb != 0) begin n_err++; $display("FAIL basic_data_hold: got %0d changes required 0", hb); end
    n_vec++; if (start_total - s0 != 6) begin n_err++; $display("FAIL basic_start_count: got %0d required 6", start_total - s0); end
    n_vec++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL basic_overrun: got %b required 0", bus.o_overrun); end
  endtask

  task automatic test_extremes();
    logic [47:0] bytes; int lat, gb, hb; logic ba, be;
    do_reset();
    run_stream(12'd0, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    n_vec++; if (bytes !== 48'h303030300D0A) begin n_err++; $display("FAIL zero_bytes: got %h required 303030300d0a", bytes); end
    idle_ticks(3);
    run_stream(12'd4095, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    n_vec++; if (bytes !== 48'h343039350D0A) begin n_err++; $display("FAIL max_bytes: got %h required 343039350d0a", bytes); end
    n_vec++; if (lat != 12) begin n_err++; $display("FAIL max_first_latency: got %0d required 12", lat); end
  endtask

  task automatic test_overrun();
    logic [47:0] bytes; int lat, gb, hb, s0; logic ba, be;
    do_reset();
    s0 = start_total;
    run_stream(12'd1230, 2, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    n_vec++; if (bytes !== 48'h313233300D0A) begin n_err++; $display("FAIL overrun_bytes: got %h required 313233300d0a", bytes); end
    n_vec++; if (bus.o_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b required 1", bus.o_overrun); end
    idle_ticks(50);
    n_vec++; if (bus.o_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b required 1", bus.o_overrun); end
    n_vec++; if (start_total - s0 != 6) begin n_err++; $display("FAIL overrun_start_count: got %0d required 6", start_total - s0); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL overrun_no_restart: busy got %b required 0", bus.o_busy); end
    do_reset();
    n_vec++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_cleared_by_rst: got %b required 0", bus.o_overrun); end
  endtask

  task automatic test_mid_reset();
    logic [47:0] bytes; int lat, gb, hb, s0, s1; logic ba, be;
    do_reset();
    s0 = start_total;
    run_stream(12'd1230, -1, 3, 1'b0, bytes, lat, gb, hb, ba, be);
    n_vec++; if (bytes[47:16] !== 32'h31323330) begin n_err++; $display("FAIL midrst_prefix: got %h required 31323330", bytes[47:16]); end
    n_vec++; if ({bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_overrun} !== 11'd0) begin
      n_err++; $display("FAIL midrst_outputs: got start=%b data=%h busy=%b ovr=%b required all 0",
                        bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_overrun);
    end
    s1 = start_total;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    idle_ticks(40);
    n_vec++; if (start_total != s1) begin n_err++; $display("FAIL midrst_late_done: got %0d extra starts required 0", start_total - s1); end
    n_vec++; if (s1 - s0 != 4) begin n_err++; $display("FAIL midrst_starts_before: got %0d required 4", s1 - s0); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_idle: got %b required 0", bus.o_busy); end
    run_stream(12'd70, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    n_vec++; if (bytes !== 48'h303037300D0A) begin n_err++; $display("FAIL midrst_restart_bytes: got %h required 303037300d0a", bytes); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] bytes; int lat, gb, hb, s0; logic ba, be;
    do_reset();
    s0 = start_total;
    run_stream(12'd1230, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    // run_stream returns in the first cycle with busy low; start straight away
    run_stream(12'd4090, -1, -1, 1'b0, bytes, lat, gb, hb, ba, be);
    idle_ticks(40);
    n_vec++; if (ba !== 1'b1) begin n_err++; $display("FAIL b2b_accepted: busy got %b required 1", ba); end
    n_vec++; if (bytes !== 48'h343039300D0A) begin n_err++; $display("FAIL b2b_bytes: got %h required 343039300d0a", bytes); end
    n_vec++; if (lat != 12) begin n_err++; $display("FAIL b2b_first_latency: got %0d required 12", lat); end
    n_vec++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b required 0", bus.o_overrun); end
    n_vec++; if (start_total - s0 != 12) begin n_err++; $display("FAIL b2b_start_count: got %0d required 12", start_total - s0); end
  endtask

  task automatic test_spurious_done();
    logic [47:0] bytes; int lat, gb, hb, s0; logic ba, be;
    do_reset();
    s0 = start_total;
    bus.i_tx_done = 1'b1;     // in IDLE
    tick();
    bus.i_tx_done = 1'b0;
    idle_ticks(3);
    n_vec++; if (start_total != s0 || bus.o_busy !== 1'b0) begin
      n_err++; $display("FAIL spur_idle: got starts=%0d busy=%b required starts=0 busy=0", start_total - s0, bus.o_busy);
    end
    run_stream(12'd1230, -1, -1, 1'b1, bytes, lat, gb, hb, ba, be);
    idle_ticks(40);
    n_vec++; if (bytes !== 48'h313233300D0A) begin n_err++; $display("FAIL spur_bytes: got %h required 313233300d0a", bytes); end
    n_vec++; if (start_total - s0 != 6) begin n_err++; $display("FAIL spur_start_count: got %0d required 6", start_total - s0); end
    n_vec++; if (gb != 0 || hb != 0) begin n_err++; $display("FAIL spur_timing: got gap=%0d hold=%0d required 0 0", gb, hb); end
    n_vec++; if (dbl_start !== 1'b0) begin n_err++; $display("FAIL consecutive_tx_start: got %b required 0", dbl_start); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_start_send = 1'b0;
    bus.i_tx_done    = 1'b0;
    bus.i_dist       = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    test_spurious_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
